// File: rtl/router_reg.sv
// Register stage behind the router FSM: latches the header, drives the FIFO write bus,
// holds the byte that arrives while the FIFO is full, and tracks packet parity.
module router_reg #(
  parameter int         DATA_WIDTH   = 8,
  parameter logic [1:0] ADDR_INVALID = 2'b11
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  pkt_valid,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  fifo_full,
  input  logic                  detect_add,
  input  logic                  lfd_state,
  input  logic                  ld_state,
  input  logic                  laf_state,
  input  logic                  full_state,
  input  logic                  rst_int_reg,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  parity_done,
  output logic                  low_packet_valid,
  output logic                  err
);

  logic [DATA_WIDTH-1:0] header_reg;
  logic [DATA_WIDTH-1:0] full_byte_reg;
  logic [DATA_WIDTH-1:0] int_parity;
  logic [DATA_WIDTH-1:0] pkt_parity;
  logic                  parity_done_p1;

  // Strobes resolved by priority: detect_add > lfd_state > ld_state > laf_state.
  logic lfd_eff, ld_eff, laf_eff, hdr_load;

  assign lfd_eff  = lfd_state && !detect_add;
  assign ld_eff   = ld_state && !detect_add && !lfd_state;
  assign laf_eff  = laf_state && !detect_add && !lfd_state && !ld_state;
  assign hdr_load = detect_add && pkt_valid && (data_in[1:0] != ADDR_INVALID);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      header_reg    <= '0;
      full_byte_reg <= '0;
      dout          <= '0;
    end else begin
      if (hdr_load)
        header_reg <= data_in;
      if (ld_eff && fifo_full)
        full_byte_reg <= data_in;
      if (lfd_eff)
        dout <= header_reg;
      else if (ld_eff && !fifo_full)
        dout <= data_in;
      else if (laf_eff)
        dout <= full_byte_reg;
    end
  end

  // The byte parked in full_byte_reg is folded in here on its ld_state cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      int_parity <= '0;
      pkt_parity <= '0;
    end else if (detect_add) begin
      int_parity <= '0;
      pkt_parity <= '0;
    end else if (lfd_eff) begin
      int_parity <= int_parity ^ header_reg;
    end else if (ld_eff) begin
      if (pkt_valid && !full_state)
        int_parity <= int_parity ^ data_in;
      if (!pkt_valid)
        pkt_parity <= data_in;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      parity_done      <= 1'b0;
      low_packet_valid <= 1'b0;
    end else begin
      if (detect_add)
        parity_done <= 1'b0;
      else if (ld_eff && !pkt_valid && !fifo_full)
        parity_done <= 1'b1;
      else if (laf_eff && low_packet_valid && !parity_done)
        parity_done <= 1'b1;
      if (ld_eff && !pkt_valid)
        low_packet_valid <= 1'b1;
      else if (rst_int_reg)
        low_packet_valid <= 1'b0;
    end
  end

  // Compare one cycle after parity_done rises, once both parity registers are final.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      parity_done_p1 <= 1'b0;
      err            <= 1'b0;
    end else begin
      parity_done_p1 <= parity_done;
      if (detect_add)
        err <= 1'b0;
      else if (parity_done && !parity_done_p1)
        err <= (int_parity != pkt_parity);
    end
  end

endmodule
